// File: rtl/snoop_bus_ctrl_if.sv
// Shared snooping-bus signal bundle between the cache controllers and the bus controller.
interface snoop_bus_ctrl_if #(
  parameter int unsigned NUM_CACHES = 2
);

  logic [NUM_CACHES-1:0]    req;
  logic [NUM_CACHES-1:0]    grant;
  logic [3*NUM_CACHES-1:0]  op_in;
  logic [5*NUM_CACHES-1:0]  addr_in;
  logic [16*NUM_CACHES-1:0] data_in;
  logic [NUM_CACHES-1:0]    done_in;
  logic [2:0]               bus_op;
  logic [4:0]               bus_addr;
  logic [15:0]              bus_data;
  logic                     bus_done;

  // Bus controller side: arbitrates, broadcasts and responds as memory.
  modport master (
    input  req, op_in, addr_in, data_in, done_in,
    output grant, bus_op, bus_addr, bus_data, bus_done
  );

  // Cache controller side.
  modport slave (
    output req, op_in, addr_in, data_in, done_in,
    input  grant, bus_op, bus_addr, bus_data, bus_done
  );

endinterface

// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus controller: round-robin arbiter, transaction broadcaster and
// 32x16 memory responder for the MSI cache controllers.
module snoop_bus_ctrl #(
  parameter int unsigned NUM_CACHES = 2,
  parameter int unsigned MEM_LAT    = 3
) (
  input  logic              clk,
  input  logic              reset,
  snoop_bus_ctrl_if.master  bus
);

  localparam int unsigned OW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_RD    = 3'b001;
  localparam logic [2:0] OP_UPGR  = 3'b010;
  localparam logic [2:0] OP_FLUSH = 3'b011;
  localparam logic [2:0] OP_RDX   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAITOP = 2'd1,
    S_MEM    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [NUM_CACHES-1:0] r_grant;
  logic [2:0]            r_bus_op;
  logic [4:0]            r_bus_addr;
  logic [15:0]           r_bus_data;
  logic                  r_bus_done;
  logic [OW-1:0]         r_ptr;
  logic [OW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;
  logic [15:0]           r_mem [32];

  logic [OW-1:0]         w_pick;
  logic                  w_pick_vld;
  logic [NUM_CACHES-1:0] w_onehot;
  int unsigned           w_dist;
  int unsigned           w_best;

  logic [2:0]            w_own_op;
  logic [4:0]            w_own_addr;
  logic [15:0]           w_own_data;
  logic                  w_own_req;
  logic                  w_own_done;
  logic                  w_snp_vld;
  logic [15:0]           w_snp_data;
  logic                  w_expire;

  // Round-robin pick: smallest rotated distance from ptr+1 among requesters.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_best     = NUM_CACHES;
    w_dist     = 0;
    for (int unsigned k = 0; k < NUM_CACHES; k++) begin
      w_dist = (k + NUM_CACHES - 32'(r_ptr) - 1) % NUM_CACHES;
      if (bus.req[k] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_pick     = OW'(k);
        w_pick_vld = 1'b1;
      end
    end
  end

  // One-hot grant vector for the picked requester.
  always_comb begin
    w_onehot = '0;
    for (int unsigned k = 0; k < NUM_CACHES; k++) begin
      w_onehot[k] = (OW'(k) == w_pick);
    end
  end

  // Owner signal mux plus lowest-index non-owner snoop flush.
  always_comb begin
    w_own_op   = OP_NONE;
    w_own_addr = '0;
    w_own_data = '0;
    w_own_req  = 1'b0;
    w_own_done = 1'b0;
    w_snp_vld  = 1'b0;
    w_snp_data = '0;
    for (int unsigned k = 0; k < NUM_CACHES; k++) begin
      if (OW'(k) == r_owner) begin
        w_own_op   = bus.op_in[3*k +: 3];
        w_own_addr = bus.addr_in[5*k +: 5];
        w_own_data = bus.data_in[16*k +: 16];
        w_own_req  = bus.req[k];
        w_own_done = bus.done_in[k];
      end else if (bus.done_in[k] && !w_snp_vld) begin
        w_snp_vld  = 1'b1;
        w_snp_data = bus.data_in[16*k +: 16];
      end
    end
  end

  assign w_expire = (r_cnt == CW'(1));

  // Bus FSM with registered outputs and backing store.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_bus_op   <= OP_NONE;
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_bus_done <= 1'b0;
      r_ptr      <= OW'(NUM_CACHES - 1);
      r_owner    <= '0;
      r_cnt      <= '0;
      r_mem      <= '{default: '0};
    end else begin
      // bus_done and bus_data are single-cycle unless set below.
      r_bus_done <= 1'b0;
      r_bus_data <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_owner <= w_pick;
            r_grant <= w_onehot;
            r_state <= S_WAITOP;
          end
        end
        S_WAITOP: begin
          if (w_own_op != OP_NONE) begin
            r_bus_op   <= w_own_op;
            r_bus_addr <= w_own_addr;
            r_cnt      <= CW'(MEM_LAT);
            r_state    <= S_MEM;
          end else if (!w_own_req) begin
            r_grant <= '0;
            r_ptr   <= r_owner;
            r_state <= S_IDLE;
          end
        end
        S_MEM: begin
          r_cnt <= r_cnt - CW'(1);
          case (r_bus_op)
            OP_RD, OP_RDX: begin
              // A snooper holding the line Modified supplies data and updates memory.
              if (w_snp_vld) begin
                r_bus_data             <= w_snp_data;
                r_mem[r_bus_addr]      <= w_snp_data;
                r_bus_done             <= 1'b1;
                r_state                <= S_DONE;
              end else if (w_expire) begin
                r_bus_data <= r_mem[r_bus_addr];
                r_bus_done <= 1'b1;
                r_state    <= S_DONE;
              end
            end
            OP_FLUSH: begin
              if (w_own_done) begin
                r_mem[r_bus_addr] <= w_own_data;
              end
              if (w_expire) begin
                r_bus_done <= 1'b1;
                r_state    <= S_DONE;
              end
            end
            default: begin
              // Upgrade (and any unused encoding) completes without data.
              r_bus_done <= 1'b1;
              r_state    <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          r_grant    <= '0;
          r_bus_op   <= OP_NONE;
          r_bus_addr <= '0;
          r_ptr      <= r_owner;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.bus_op   = r_bus_op;
  assign bus.bus_addr = r_bus_addr;
  assign bus.bus_data = r_bus_data;
  assign bus.bus_done = r_bus_done;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: directed vector table, corner-case
// sequences and random transactions against a transaction-level memory model.
module tb_snoop_bus_ctrl;

  localparam int NC  = 2;
  localparam int LAT = 3;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_RD    = 3'b001;
  localparam logic [2:0] OP_UPGR  = 3'b010;
  localparam logic [2:0] OP_FLUSH = 3'b011;
  localparam logic [2:0] OP_RDX   = 3'b100;

  typedef struct {
    int         k;
    logic [2:0] op;
    logic [4:0] a;
    logic [15:0] d;
    int         snp;
    int         scyc;
    logic [15:0] sd;
    int         elat;
    logic [15:0] edata;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] mem_model [32];

  snoop_bus_ctrl_if #(.NUM_CACHES(NC)) bif ();

  snoop_bus_ctrl #(.NUM_CACHES(NC), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bif.req     = '0;
    bif.op_in   = '0;
    bif.addr_in = '0;
    bif.data_in = '0;
    bif.done_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem_model[i] = 16'h0000;
  endtask

  // One full transaction by cache k with only k requesting. For Rd/RdX, snp>=0
  // makes that cache flush in MEM cycle scyc. For Flush, the owner's done_in
  // rises in MEM cycle scyc (0 = already high when the op is presented).
  task automatic txn(input int k, input logic [2:0] op, input logic [4:0] a, input logic [15:0] d,
                     input int snp, input int scyc, input logic [15:0] sd,
                     output int lat, output logic [15:0] got);
    lat = -1;
    got = 16'h0;
    @(negedge clk);
    bif.req    = '0;
    bif.req[k] = 1'b1;
    @(posedge clk); #1;
    chk("grant_onehot", 32'(bif.grant), 32'(1 << k));
    bif.op_in[3*k +: 3]    = op;
    bif.addr_in[5*k +: 5]  = a;
    bif.data_in[16*k +: 16] = d;
    if (op == OP_FLUSH && scyc == 0) bif.done_in[k] = 1'b1;
    @(posedge clk); #1;
    chk("bus_op", 32'(bif.bus_op), 32'(op));
    chk("bus_addr", 32'(bif.bus_addr), 32'(a));
    for (int n = 1; n <= 16; n++) begin
      if (op == OP_FLUSH && n == scyc) bif.done_in[k] = 1'b1;
      if (op != OP_FLUSH && snp >= 0 && n == scyc) begin
        bif.done_in[snp] = 1'b1;
        bif.data_in[16*snp +: 16] = sd;
      end
      @(posedge clk); #1;
      if (bif.bus_done) begin
        lat = n;
        got = bif.bus_data;
        break;
      end
      chk("data_zero_idle", 32'(bif.bus_data), 32'h0);
      chk("bus_op_held", 32'(bif.bus_op), 32'(op));
      if (op != OP_FLUSH && snp >= 0) bif.done_in[snp] = 1'b0;
    end
    if (lat < 0) chk("done_timeout", 32'h0, 32'h1);
    clear_inputs();
    @(posedge clk); #1;
    chk("no_second_done", 32'(bif.bus_done), 32'h0);
    chk("grant_release", 32'(bif.grant), 32'h0);
    chk("bus_op_release", 32'(bif.bus_op), 32'(OP_NONE));
  endtask

  function automatic int exp_lat(input logic [2:0] op, input int snp, input int scyc);
    if (op == OP_UPGR) return 1;
    if ((op == OP_RD || op == OP_RDX) && snp >= 0) return scyc;
    return LAT;
  endfunction

  vec_t tbl [12];

  initial begin
    int          lat;
    logic [15:0] got;
    int          cyc;
    int          tg;
    int          gi;
    int          ndone;
    logic        prev_done;
    logic [NC-1:0] prev_grant;
    logic [NC-1:0] rr_exp [4];

    reset = 1'b1;
    clear_inputs();

    tbl[0]  = '{0, OP_RD,    5'h0A, 16'h0000, -1, 0, 16'h0000, 3, 16'h0000};
    tbl[1]  = '{0, OP_FLUSH, 5'h0A, 16'hBEEF, -1, 0, 16'h0000, 3, 16'h0000};
    tbl[2]  = '{1, OP_RD,    5'h0A, 16'h0000, -1, 0, 16'h0000, 3, 16'hBEEF};
    tbl[3]  = '{0, OP_RD,    5'h0A, 16'h0000,  1, 2, 16'h1234, 2, 16'h1234};
    tbl[4]  = '{1, OP_RDX,   5'h0A, 16'h0000, -1, 0, 16'h0000, 3, 16'h1234};
    tbl[5]  = '{0, OP_UPGR,  5'h03, 16'h0000, -1, 0, 16'h0000, 1, 16'h0000};
    tbl[6]  = '{1, OP_RD,    5'h03, 16'h0000,  0, 3, 16'h5555, 3, 16'h5555};
    tbl[7]  = '{0, OP_RD,    5'h03, 16'h0000, -1, 0, 16'h0000, 3, 16'h5555};
    tbl[8]  = '{1, OP_FLUSH, 5'h1F, 16'h0F0F, -1, 2, 16'h0000, 3, 16'h0000};
    tbl[9]  = '{0, OP_RDX,   5'h1F, 16'h0000, -1, 0, 16'h0000, 3, 16'h0F0F};
    tbl[10] = '{1, OP_FLUSH, 5'h00, 16'hAAAA, -1, 3, 16'h0000, 3, 16'h0000};
    tbl[11] = '{0, OP_RD,    5'h00, 16'h0000, -1, 0, 16'h0000, 3, 16'hAAAA};

    // Reset state.
    do_reset();
    #1;
    chk("rst_grant", 32'(bif.grant), 32'h0);
    chk("rst_bus_op", 32'(bif.bus_op), 32'h0);
    chk("rst_bus_addr", 32'(bif.bus_addr), 32'h0);
    chk("rst_bus_data", 32'(bif.bus_data), 32'h0);
    chk("rst_bus_done", 32'(bif.bus_done), 32'h0);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].k, tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].snp, tbl[i].scyc, tbl[i].sd, lat, got);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].elat));
      chk($sformatf("tbl%0d_data", i), 32'(got), 32'(tbl[i].edata));
    end

    // Both caches request continuously with back-to-back upgrades.
    do_reset();
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    bif.req     = 2'b11;
    bif.op_in   = {OP_UPGR, OP_UPGR};
    bif.addr_in = {5'h12, 5'h11};
    tg = -100; gi = 0; ndone = 0; prev_done = 1'b0; prev_grant = '0;
    for (cyc = 0; cyc < 60 && ndone < 4; cyc++) begin
      @(posedge clk); #1;
      chk("rr_onehot0", 32'($onehot0(bif.grant)), 32'h1);
      if (bif.grant != '0 && prev_grant == '0) begin
        if (gi < 4) chk($sformatf("rr_grant%0d", gi), 32'(bif.grant), 32'(rr_exp[gi]));
        gi++;
        tg = cyc;
      end
      if (bif.bus_done) begin
        chk("rr_done_lat", 32'(cyc - tg), 32'd2);
        chk("rr_done_consec", 32'(prev_done), 32'h0);
        ndone++;
        if (ndone == 4) clear_inputs();
      end
      prev_done  = bif.bus_done;
      prev_grant = bif.grant;
    end
    chk("rr_done_count", 32'(ndone), 32'd4);
    clear_inputs();
    repeat (2) @(posedge clk);

    // Cache1 abandons its grant in WAITOP; arbitration resumes after it.
    txn(0, OP_FLUSH, 5'h0A, 16'hBEEF, -1, 0, 16'h0, lat, got);
    @(negedge clk);
    bif.req = 2'b10;
    @(posedge clk); #1;
    chk("drop_grant1", 32'(bif.grant), 32'h2);
    bif.req = 2'b01;
    @(posedge clk); #1;
    chk("drop_grant0", 32'(bif.grant), 32'h0);
    chk("drop_no_done", 32'(bif.bus_done), 32'h0);
    bif.req = 2'b11;
    @(posedge clk); #1;
    chk("drop_next_owner", 32'(bif.grant), 32'h1);
    bif.req = 2'b00;
    @(posedge clk); #1;
    chk("drop_abort_idle", 32'(bif.grant), 32'h0);

    // Reset lands in the MEM cycle of a flush to 0A.
    @(negedge clk);
    bif.req = 2'b01;
    @(posedge clk); #1;
    bif.op_in[2:0]   = OP_FLUSH;
    bif.addr_in[4:0] = 5'h0A;
    bif.data_in[15:0] = 16'h7777;
    bif.done_in[0]   = 1'b1;
    @(posedge clk); #1;
    chk("mr_in_mem", 32'(bif.bus_op), 32'(OP_FLUSH));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_grant", 32'(bif.grant), 32'h0);
    chk("mr_bus_op", 32'(bif.bus_op), 32'h0);
    chk("mr_bus_addr", 32'(bif.bus_addr), 32'h0);
    chk("mr_bus_done", 32'(bif.bus_done), 32'h0);
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem_model[i] = 16'h0000;
    @(negedge clk);
    bif.req = 2'b11;
    @(posedge clk); #1;
    chk("mr_fresh_arb", 32'(bif.grant), 32'h1);
    bif.req = 2'b00;
    @(posedge clk);
    txn(0, OP_RD, 5'h0A, 16'h0, -1, 0, 16'h0, lat, got);
    chk("mr_mem_cleared", 32'(got), 32'h0000);

    // Random transactions against the memory model.
    for (int i = 0; i < 60; i++) begin
      int          k, snp, scyc, el;
      logic [2:0]  op;
      logic [4:0]  a;
      logic [15:0] d, sd, ed;
      k    = int'($urandom_range(0, NC - 1));
      a    = 5'($urandom_range(0, 7));
      d    = 16'($urandom);
      sd   = 16'($urandom);
      snp  = -1;
      scyc = 0;
      case ($urandom_range(0, 3))
        0: op = OP_RD;
        1: op = OP_RDX;
        2: op = OP_UPGR;
        default: op = OP_FLUSH;
      endcase
      if ((op == OP_RD || op == OP_RDX) && $urandom_range(0, 1) == 1) begin
        snp  = 1 - k;
        scyc = int'($urandom_range(1, LAT));
      end
      if (op == OP_FLUSH) scyc = int'($urandom_range(0, LAT));
      el = exp_lat(op, snp, scyc);
      if (op == OP_RD || op == OP_RDX) ed = (snp >= 0) ? sd : mem_model[a];
      else ed = 16'h0000;
      txn(k, op, a, d, snp, scyc, sd, lat, got);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(el));
      chk($sformatf("rnd%0d_data", i), 32'(got), 32'(ed));
      if (op == OP_FLUSH) mem_model[a] = d;
      if ((op == OP_RD || op == OP_RDX) && snp >= 0) mem_model[a] = sd;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
